spi_divider: RTL and testbench
==============================

Name: spi_divider

Overview:
- SPI-slave coprocessor performing 32-bit integer division and remainder.
- Sits downstream of the CPU's SPI master, alongside the ALU, multiplier and barrel shifter slaves.
- Accepts the standard CPU frame: 4-bit opcode, operand A, operand B, 8 wait bits, then returns a 32-bit result.
- Divides iteratively during the wait phase.

Parameters:
- DATA_WIDTH, 32: operand/result width.
- OP_WIDTH, 4: opcode field width.
- WAIT_BITS, 8: sclk rising edges between last B bit and first result bit.
- SYNC_STAGES, 2: synchronizer depth for sclk/mosi/nss.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- sclk  input  1  SPI clock from master (clock/8 typical), asynchronous to clock.
- mosi  input  1  serial data in, MSB first.
- nss  input  1  active-low slave select.
- miso  output  1  serial result out, MSB first.
- busy  output  1  high from first opcode bit until frame end or abort.
- frame_done  output  1  one-clock pulse after the last result bit is shifted out.
- err  output  1  sticky per frame: unsupported opcode, or result not ready at TX start; cleared at next frame start.

Behaviour:
- Reset (reset=0, async): state=IDLE, counters 0, shift regs 0, miso=0, busy=0, frame_done=0, err=0.
- sclk, mosi, nss pass through SYNC_STAGES flops. Edges are detected from the synchronized sclk and its previous value.
- RX: mosi is sampled on each synchronized sclk rising edge while nss_s=0.
- States and transitions:
  - IDLE -> RX_OP on nss_s falling; clears counter, sets busy, clears err.
  - RX_OP: 4 rising edges -> RX_A.
  - RX_A: 32 rising edges -> RX_B.
  - RX_B: 32 rising edges -> WAIT. The divider starts on the clock after the last B bit.
  - WAIT: WAIT_BITS rising edges -> TX. On entry to TX, miso=result[31].
  - TX: each further rising edge shifts the next bit onto miso, so the master captures on falling edges. After 32 bits are presented, the next rising edge (or nss_s rising) -> DONE.
  - DONE: frame_done=1 for one clock, busy=0, miso=0 -> IDLE.
- Divider:
  - Restoring, one quotient bit per clock; 32 clocks + 1 setup clock + 1 sign-fix clock.
  - Signed opcodes use magnitudes, then apply sign correction.
  - Must finish before TX. If not finished at TX entry: result=0, err=1.
- Opcodes:
  - 4'hA DIVU: unsigned quotient.
  - 4'hB REMU: unsigned remainder.
  - 4'hC DIV: signed quotient, truncating toward zero.
  - 4'hD REM: signed remainder, sign of dividend.
  - Any other opcode: result=0, err=1, frame still completes normally.
- Divide by zero: quotient=32'hFFFFFFFF; remainder=A; err not set.
- Signed overflow (A=32'h80000000, B=32'hFFFFFFFF): quotient=32'h80000000, remainder=0.
- nss_s rising before TX completes: abort. Return to IDLE, miso=0, busy=0, no frame_done pulse, divider discarded.
- nss_s falling while not IDLE is ignored; only IDLE starts a frame.
- Reset mid-frame: immediate return to reset values; the next frame must begin with a fresh nss falling edge.
- miso is 0 whenever not in TX.

Optional Feature:
- SPI_DIVIDER_SIGNED_EN
- Defined: opcodes C/D supported as above.
- Undefined: C/D are treated as unsupported (result 0, err=1), and the sign-fix logic and sign-fix clock are removed.

Test Plan:
- DIVU, A=100, B=7 -> miso shifts 32'h0000000E; frame_done pulses once; err=0.
- REMU, A=100, B=7 -> result 32'h00000002. DIV, A=-100 (32'hFFFFFF9C), B=7 -> 32'hFFFFFFF2. REM, same operands -> 32'hFFFFFFFE (signed cases only with macro defined).
- DIVU, B=0, A=32'h1234 -> quotient 32'hFFFFFFFF. REMU, B=0 -> 32'h00001234. DIV, A=32'h80000000, B=-1 -> 32'h80000000.
- Opcode 4'h3, A=5, B=5 -> result 0, err=1, frame_done pulses. The next valid DIVU 9/3 frame returns 3 and clears err.
- nss raised after 20 bits of A -> busy=0 within SYNC_STAGES+1 clocks, no frame_done. A following DIVU 50/5 frame returns 10.
- reset asserted during WAIT -> miso=0, busy=0 immediately. After release, DIVU 32'hFFFFFFFF/1 returns 32'hFFFFFFFF.

Source files
------------

// File: rtl/spi_divider_if.sv
// SPI-side signals of the divider coprocessor.
// The master drives the serial lines; the slave returns the result bit stream and frame status.
interface spi_divider_if;
  logic sclk;
  logic mosi;
  logic nss;
  logic miso;
  logic busy;
  logic frame_done;
  logic err;

  modport master (output sclk, mosi, nss, input miso, busy, frame_done, err);
  modport slave  (input sclk, mosi, nss, output miso, busy, frame_done, err);
endinterface

// File: rtl/spi_divider.sv
// SPI-slave 32-bit divide/remainder coprocessor: frame is opcode, A, B, wait bits, then the result.
// SPI_DIVIDER_SIGNED_EN adds signed DIV/REM opcodes and the sign-fix clock.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for nss falling edge
// RX_OP   | shifting in the opcode
// RX_A    | shifting in the dividend
// RX_B    | shifting in the divisor; divider starts after last bit
// WAIT    | wait bits while the divider iterates
// TX      | result shifted out on miso, one bit per sclk rising edge
// DONE    | one-clock frame_done pulse
module spi_divider #(
  parameter int DATA_WIDTH  = 32,
  parameter int OP_WIDTH    = 4,
  parameter int WAIT_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic          clock,
  input logic          reset,
  spi_divider_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] OP_LAST   = CNT_W'(OP_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_BITS - 1);
  localparam logic [CNT_W-1:0] TX_FULL   = CNT_W'(DATA_WIDTH);
  localparam logic [OP_WIDTH-1:0] OP_DIVU = OP_WIDTH'(4'hA);
  localparam logic [OP_WIDTH-1:0] OP_REMU = OP_WIDTH'(4'hB);
`ifdef SPI_DIVIDER_SIGNED_EN
  localparam logic [OP_WIDTH-1:0] OP_DIV  = OP_WIDTH'(4'hC);
  localparam logic [OP_WIDTH-1:0] OP_REM  = OP_WIDTH'(4'hD);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_RX_OP, S_RX_A, S_RX_B, S_WAIT, S_TX, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    DV_IDLE, DV_RUN, DV_FIX, DV_DONE
  } dv_state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, nss_sync;
  logic sclk_s, mosi_s, nss_s;
  logic sclk_q, nss_q;
  logic sclk_rise, nss_fall, nss_rise, rx_edge;

  state_t state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, tx_q, tx_d;
  logic miso_q, miso_d, busy_q, busy_d, err_q, err_d, done_q, done_d;
  logic div_start, start_q, div_clear;
  logic go_abort, go_done;

  dv_state_t dv_state_q, dv_state_d;
  logic [DATA_WIDTH-1:0] dvd_q, rem_q, dvs_q;
  logic [CNT_W-1:0]      it_q;
  logic                  rem_sel_q;
  logic [DATA_WIDTH:0]   r_shift;
  logic [DATA_WIDTH-1:0] rem_step, a_mag, b_mag, div_result, tx_res;
  logic                  take, div_done, rem_op;
`ifdef SPI_DIVIDER_SIGNED_EN
  logic sgn_op, a_neg, b_neg;
  logic neg_quo_q, neg_rem_q, bzero_q;
`endif

  function automatic logic op_supported(input logic [OP_WIDTH-1:0] op);
`ifdef SPI_DIVIDER_SIGNED_EN
    return (op == OP_DIVU) || (op == OP_REMU) || (op == OP_DIV) || (op == OP_REM);
`else
    return (op == OP_DIVU) || (op == OP_REMU);
`endif
  endfunction

  // Sync flops reset low so a slave select held low across reset is not seen as a new frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      nss_sync  <= '0;
      sclk_q    <= 1'b0;
      nss_q     <= 1'b0;
    end else begin
      sclk_sync[0] <= bus.sclk;
      mosi_sync[0] <= bus.mosi;
      nss_sync[0]  <= bus.nss;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync[i] <= sclk_sync[i-1];
        mosi_sync[i] <= mosi_sync[i-1];
        nss_sync[i]  <= nss_sync[i-1];
      end
      sclk_q <= sclk_s;
      nss_q  <= nss_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign nss_s     = nss_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign nss_fall  = ~nss_s & nss_q;
  assign nss_rise  = nss_s & ~nss_q;
  assign rx_edge   = sclk_rise & ~nss_s;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tx_q    <= '0;
      miso_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      miso_q  <= miso_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      done_q  <= done_d;
      start_q <= div_start;
    end
  end

  assign div_done   = (dv_state_q == DV_DONE);
  assign div_result = rem_sel_q ? rem_q : dvd_q;
  assign tx_res     = (div_done && op_supported(op_q)) ? div_result : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    tx_d      = tx_q;
    miso_d    = 1'b0;
    busy_d    = busy_q;
    err_d     = err_q;
    done_d    = 1'b0;
    div_start = 1'b0;
    div_clear = 1'b0;
    go_abort  = 1'b0;
    go_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (nss_fall) begin
          state_d = S_RX_OP;
          cnt_d   = '0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      S_RX_OP: begin
        if (nss_rise) go_abort = 1'b1;
        else if (rx_edge) begin
          op_d = {op_q[OP_WIDTH-2:0], mosi_s};
          if (cnt_q == OP_LAST) begin
            state_d = S_RX_A;
            cnt_d   = '0;
            if (!op_supported(op_d)) err_d = 1'b1;
          end else cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RX_A: begin
        if (nss_rise) go_abort = 1'b1;
        else if (rx_edge) begin
          a_d = {a_q[DATA_WIDTH-2:0], mosi_s};
          if (cnt_q == DATA_LAST) begin
            state_d = S_RX_B;
            cnt_d   = '0;
          end else cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RX_B: begin
        if (nss_rise) go_abort = 1'b1;
        else if (rx_edge) begin
          b_d = {b_q[DATA_WIDTH-2:0], mosi_s};
          if (cnt_q == DATA_LAST) begin
            state_d   = S_WAIT;
            cnt_d     = '0;
            div_start = 1'b1;
          end else cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (nss_rise) go_abort = 1'b1;
        else if (rx_edge) begin
          if (cnt_q == WAIT_LAST) begin
            state_d = S_TX;
            cnt_d   = CNT_W'(1);
            miso_d  = tx_res[DATA_WIDTH-1];
            tx_d    = {tx_res[DATA_WIDTH-2:0], 1'b0};
            if (!div_done) err_d = 1'b1;
          end else cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_TX: begin
        miso_d = miso_q;
        if (nss_rise) begin
          if (cnt_q == TX_FULL) go_done = 1'b1;
          else go_abort = 1'b1;
        end else if (rx_edge) begin
          if (cnt_q == TX_FULL) go_done = 1'b1;
          else begin
            miso_d = tx_q[DATA_WIDTH-1];
            tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (go_done) begin
      state_d   = S_DONE;
      cnt_d     = '0;
      done_d    = 1'b1;
      busy_d    = 1'b0;
      miso_d    = 1'b0;
      div_clear = 1'b1;
    end
    if (go_abort) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      busy_d    = 1'b0;
      miso_d    = 1'b0;
      div_clear = 1'b1;
    end
  end

  assign bus.miso       = miso_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.err        = err_q;

  // Divider operates on magnitudes; signs are re-applied in the fix clock.
`ifdef SPI_DIVIDER_SIGNED_EN
  assign sgn_op = (op_q == OP_DIV) || (op_q == OP_REM);
  assign a_neg  = sgn_op & a_q[DATA_WIDTH-1];
  assign b_neg  = sgn_op & b_q[DATA_WIDTH-1];
  assign a_mag  = a_neg ? -a_q : a_q;
  assign b_mag  = b_neg ? -b_q : b_q;
  assign rem_op = (op_q == OP_REMU) || (op_q == OP_REM);
`else
  assign a_mag  = a_q;
  assign b_mag  = b_q;
  assign rem_op = (op_q == OP_REMU);
`endif

  assign r_shift  = {rem_q, dvd_q[DATA_WIDTH-1]};
  assign take     = (r_shift >= {1'b0, dvs_q});
  assign rem_step = take ? (r_shift[DATA_WIDTH-1:0] - dvs_q) : r_shift[DATA_WIDTH-1:0];

  always_comb begin
    dv_state_d = dv_state_q;
    case (dv_state_q)
      DV_RUN: begin
        if (it_q == '0) begin
`ifdef SPI_DIVIDER_SIGNED_EN
          dv_state_d = DV_FIX;
`else
          dv_state_d = DV_DONE;
`endif
        end
      end
      DV_FIX:  dv_state_d = DV_DONE;
      default: dv_state_d = dv_state_q;
    endcase
    if (start_q)   dv_state_d = DV_RUN;
    if (div_clear) dv_state_d = DV_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dv_state_q <= DV_IDLE;
      dvd_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      it_q       <= '0;
      rem_sel_q  <= 1'b0;
`ifdef SPI_DIVIDER_SIGNED_EN
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      bzero_q    <= 1'b0;
`endif
    end else begin
      dv_state_q <= dv_state_d;
      if (start_q) begin
        dvd_q     <= a_mag;
        dvs_q     <= b_mag;
        rem_q     <= '0;
        it_q      <= DATA_LAST;
        rem_sel_q <= rem_op;
`ifdef SPI_DIVIDER_SIGNED_EN
        neg_quo_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        bzero_q   <= (b_q == '0);
`endif
      end else if (dv_state_q == DV_RUN) begin
        rem_q <= rem_step;
        dvd_q <= {dvd_q[DATA_WIDTH-2:0], take};
        it_q  <= it_q - CNT_W'(1);
      end
`ifdef SPI_DIVIDER_SIGNED_EN
      // Divide by zero keeps the all-ones quotient; negating |A| restores A as the remainder.
      else if (dv_state_q == DV_FIX) begin
        if (neg_quo_q && !bzero_q) dvd_q <= -dvd_q;
        if (neg_rem_q) rem_q <= -rem_q;
      end
`endif
    end
  end

endmodule

// File: tb/tb_spi_divider.sv
// Self-checking bench for spi_divider: full SPI frames, expected results queued per frame.
module tb_spi_divider;
  localparam int HALF = 8;
  localparam int SYNC = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  int fd_count = 0;

  typedef struct {
    logic [31:0] res;
    logic        err;
  } exp_t;
  exp_t sb[$];

  spi_divider_if bus();

  spi_divider #(
    .DATA_WIDTH(32), .OP_WIDTH(4), .WAIT_BITS(8), .SYNC_STAGES(SYNC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (bus.frame_done === 1'b1) fd_count++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic shift_bit(input logic b);
    bus.mosi = b;
    tick(HALF);
    bus.sclk = 1'b1;
    tick(HALF);
    bus.sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [67:0] w, input int n);
    for (int i = 0; i < n; i++) shift_bit(w[67-i]);
  endtask

  task automatic rise_fall(output logic s);
    tick(HALF);
    bus.sclk = 1'b1;
    tick(HALF);
    s = bus.miso;
    bus.sclk = 1'b0;
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [31:0] sa, sb_;
    sa = a;
    sb_ = b;
    e.res = '0;
    e.err = 1'b0;
    case (op)
      4'hA: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'hB: e.res = (b == 0) ? a : a % b;
`ifdef SPI_DIVIDER_SIGNED_EN
      4'hC: begin
        if (b == 0) e.res = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = 32'h8000_0000;
        else e.res = sa / sb_;
      end
      4'hD: begin
        if (b == 0) e.res = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e.res = '0;
        else e.res = sa % sb_;
      end
`endif
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic do_frame(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
    logic [31:0] got;
    logic s;
    exp_t e;
    int fd0;
    sb.push_back(model(op, a, b));
    fd0 = fd_count;
    got = '0;
    bus.nss = 1'b0;
    tick(HALF);
    send_bits({op, a, b}, 68);
    check({tag, ".busy"}, bus.busy, 1);
    for (int i = 0; i < 7; i++) rise_fall(s);
    for (int i = 31; i >= 0; i--) begin
      rise_fall(s);
      got[i] = s;
    end
    tick(HALF);
    bus.sclk = 1'b1;
    tick(HALF);
    bus.sclk = 1'b0;
    tick(HALF);
    bus.nss = 1'b1;
    tick(2 * HALF);
    e = sb.pop_front();
    check({tag, ".res"}, got, e.res);
    check({tag, ".err"}, bus.err, e.err);
    check({tag, ".fdone"}, fd_count - fd0, 1);
    check({tag, ".idle"}, {bus.busy, bus.miso}, 0);
  endtask

  initial begin
    logic s;
    int fd0;
    logic [3:0] op;
    logic [31:0] ra, rb;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.nss  = 1'b1;
    tick(4);
    check("rst.miso", bus.miso, 0);
    check("rst.busy", bus.busy, 0);
    check("rst.fdone", bus.frame_done, 0);
    check("rst.err", bus.err, 0);
    reset = 1'b1;
    tick(8);

    do_frame(4'hA, 32'd100, 32'd7, "divu");
    do_frame(4'hB, 32'd100, 32'd7, "remu");
    do_frame(4'hC, 32'hFFFF_FF9C, 32'd7, "div");
    do_frame(4'hD, 32'hFFFF_FF9C, 32'd7, "rem");
    do_frame(4'hA, 32'h1234, 32'd0, "divu0");
    do_frame(4'hB, 32'h1234, 32'd0, "remu0");
    do_frame(4'hC, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_frame(4'hD, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    do_frame(4'hC, 32'hFFFF_FFFB, 32'd0, "div0s");
    do_frame(4'hD, 32'hFFFF_FFFB, 32'd0, "rem0s");
    do_frame(4'h3, 32'd5, 32'd5, "badop");
    do_frame(4'hA, 32'd9, 32'd3, "after_bad");

    fd0 = fd_count;
    bus.nss = 1'b0;
    tick(HALF);
    send_bits({4'hA, 32'd50, 32'd5}, 24);
    bus.nss = 1'b1;
    tick(SYNC + 1);
    check("abort.busy", bus.busy, 0);
    tick(6 * HALF);
    check("abort.fdone", fd_count - fd0, 0);
    check("abort.miso", bus.miso, 0);
    do_frame(4'hA, 32'd50, 32'd5, "post_abort");

    bus.nss = 1'b0;
    tick(HALF);
    send_bits({4'hA, 32'd77, 32'd3}, 68);
    for (int i = 0; i < 3; i++) rise_fall(s);
    check("wait.busy", bus.busy, 1);
    reset = 1'b0;
    #1;
    check("rstmid.miso", bus.miso, 0);
    check("rstmid.busy", bus.busy, 0);
    check("rstmid.fdone", bus.frame_done, 0);
    bus.nss = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(8);
    do_frame(4'hA, 32'hFFFF_FFFF, 32'd1, "post_rst");

    for (int k = 0; k < 4; k++) begin
      op = 4'hA + 4'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      do_frame(op, ra, rb, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
